seq_alu: RTL
============

# seq_alu

Parametrised, registered successor to the datapath's combinational ALU. Widens operands to `WIDTH` bits and registers all results behind a start/done handshake. Adds status flags and a multi-cycle signed shift-add multiply producing a full 2·`WIDTH` product. Sits between register-file read ports and the writeback mux; the controller issues `start` and waits for `done`.

## Interface
- `WIDTH`, 16, operand/result width in bits (≥ 4)
- `clk`  in  1  system clock, rising-edge
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  request; sampled only while `busy`=0
- `op`  in  3  000 zero, 001 add, 010 sub, 011 and, 100 or, 101 not B, 110 signed mul, 111 reserved (result 0)
- `a`, `b`  in  `WIDTH`  signed operands, sampled with `start`
- `busy`  out  1  multiply in progress
- `done`  out  1  one-cycle pulse: result/flags updated
- `result`  out  `WIDTH`  low result word
- `result_hi`  out  `WIDTH`  high product word (mul); sign-extension of `result` for other ops
- `zero`, `neg`, `carry`, `ovf`  out  1 each  status flags

## Operation
- States: IDLE, MUL, FIX.
- IDLE, `start`=1, `op`≠110: compute in that edge, register `result`/`result_hi`/flags, pulse `done`; stay IDLE.
- IDLE, `start`=1, `op`=110: load |a|, |b| (as `WIDTH`-bit unsigned), the product sign a[W-1]^b[W-1], clear the 2W accumulator and the iteration counter, set `busy`, go to MUL.
- MUL: one shift-add iteration per cycle (add shifted multiplicand when current multiplier bit is 1). After `WIDTH` iterations go to FIX.
- FIX: negate the accumulator if the sign is set, write `{result_hi,result}`, pulse `done`, clear `busy`, go to IDLE.
- |−2^(W−1)| = 2^(W−1) must be handled correctly as unsigned.
- Flags, computed on the written value:
  - `zero` = (`result`==0), low word only.
  - `neg` = `result`[W−1].
  - `carry` = carry-out of a+b (add) or of a+~b+1 (sub); 0 otherwise.
  - `ovf` = signed overflow for add/sub; for mul, 1 iff `result_hi` ≠ W copies of `result`[W−1]; 0 otherwise.
- `start` while `busy`=1: ignored. No queuing, no effect on the operation in flight.
- `result`, `result_hi` and flags hold their values between `done` pulses.
- `op`/`a`/`b` changes during MUL/FIX: no effect; operands are captured.

## Timing
- Reset (async, mid-operation included): state IDLE; `busy`=0, `done`=0, `result`=0, `result_hi`=0, `zero`=1, `neg`=0, `carry`=0, `ovf`=0. An aborted multiply produces no `done`.
- Let E0 be the edge that samples `start`=1 in IDLE.
- Non-mul ops: `done`=1 for exactly the cycle after E0 (latency 1). Back-to-back `start` every cycle gives a `done` every cycle.
- Mul: `busy`=1 from E0 until edge E0+`WIDTH`+1. `done`=1 for the single cycle after E0+`WIDTH`+1 (latency `WIDTH`+1; 17 at default), with `busy`=0 in that same cycle.
- `start` in the `done` cycle of a multiply is accepted (IDLE).
- `done` is never high for two consecutive cycles from one request.

## Test plan
- Reset, then idle 5 cycles: all outputs at reset values; `done` stays 0.
- add a=0x7FFF, b=0x0001: next cycle `done`=1, `result`=0x8000, `neg`=1, `ovf`=1, `carry`=0, `result_hi`=0xFFFF. Then sub a=5, b=5: `result`=0, `zero`=1, `carry`=1, `ovf`=0.
- mul a=−3 (0xFFFD), b=7: `busy` high 17 cycles, `done` at cycle 17, `result`=0xFFEB, `result_hi`=0xFFFF, `ovf`=0, `neg`=1. Then mul 0x8000×0x8000: `result_hi`=0x4000, `result`=0x0000, `zero`=1, `ovf`=1.
- During a multiply, pulse `start` with op=001, a=1, b=1 at cycles 3 and 10: ignored; only one `done`, carrying the mul result.
- Assert `rst` at cycle 8 of a multiply: immediate reset values, no `done`; a subsequent op=011 with a=0xF0F0, b=0x0FF0 gives `result`=0x00F0 after 1 cycle.
- op=101 with b=0x00FF gives 0xFF00; op=111 and op=000 give `result`=0, `zero`=1; flags held stable across 10 idle cycles afterwards.

Source files
------------

// File: rtl/seq_alu_if.sv
// Handshake and result bundle between the controller and the registered ALU.
// The controller drives start/op/a/b, and the ALU returns its status and results.
interface seq_alu_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zero;
    logic             neg;
    logic             carry;
    logic             ovf;

    modport master (
        output start, op, a, b,
        input  busy, done, result, result_hi, zero, neg, carry, ovf
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, result_hi, zero, neg, carry, ovf
    );
endinterface

// File: rtl/seq_alu.sv
// Registered ALU with a start/done handshake and status flags.
// Signed multiply is done as WIDTH shift-add steps on magnitudes, followed by a sign fix-up.
module seq_alu #(
    parameter int WIDTH = 16
) (
    input  logic       clk,
    input  logic       rst,
    seq_alu_if.slave   bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;

    typedef enum logic [1:0] {IDLE, MUL, FIX} state_t;

    state_t               state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 sign_q, sign_d;
    logic [WIDTH-1:0]     result_q, result_d;
    logic [WIDTH-1:0]     result_hi_q, result_hi_d;
    logic                 zero_q, zero_d;
    logic                 neg_q, neg_d;
    logic                 carry_q, carry_d;
    logic                 ovf_q, ovf_d;
    logic                 done_q, done_d;

    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [WIDTH-1:0]     add_b;
    logic [WIDTH:0]       sum_w;
    logic [2*WIDTH-1:0]   prod;
    logic [WIDTH-1:0]     alu_res;
    logic                 alu_carry, alu_ovf;

    // Negating the most negative value yields 2^(W-1), which is still correct when read as unsigned.
    assign abs_a = bus.a[WIDTH-1] ? -bus.a : bus.a;
    assign abs_b = bus.b[WIDTH-1] ? -bus.b : bus.b;
    assign prod  = sign_q ? -acc_q : acc_q;

    // Subtraction is computed as a + ~b + 1, so one adder serves both add and sub.
    assign add_b = (bus.op == OP_SUB) ? ~bus.b : bus.b;
    assign sum_w = {1'b0, bus.a} + {1'b0, add_b} + {{WIDTH{1'b0}}, (bus.op == OP_SUB)};

    always_comb begin
        alu_res   = '0;
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (bus.op)
            OP_ADD, OP_SUB: begin
                alu_res   = sum_w[WIDTH-1:0];
                alu_carry = sum_w[WIDTH];
                alu_ovf   = (bus.a[WIDTH-1] == add_b[WIDTH-1]) &&
                            (sum_w[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OP_AND:  alu_res = bus.a & bus.b;
            OP_OR:   alu_res = bus.a | bus.b;
            OP_NOT:  alu_res = ~bus.b;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mcand_d     = mcand_q;
        acc_d       = acc_q;
        mplier_d    = mplier_q;
        cnt_d       = cnt_q;
        sign_d      = sign_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        neg_d       = neg_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        done_d      = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    if (bus.op == OP_MUL) begin
                        mcand_d  = {{WIDTH{1'b0}}, abs_a};
                        mplier_d = abs_b;
                        sign_d   = bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
                        acc_d    = '0;
                        cnt_d    = '0;
                        state_d  = MUL;
                    end else begin
                        result_d    = alu_res;
                        result_hi_d = {WIDTH{alu_res[WIDTH-1]}};
                        zero_d      = (alu_res == '0);
                        neg_d       = alu_res[WIDTH-1];
                        carry_d     = alu_carry;
                        ovf_d       = alu_ovf;
                        done_d      = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                result_d    = prod[WIDTH-1:0];
                result_hi_d = prod[2*WIDTH-1:WIDTH];
                zero_d      = (prod[WIDTH-1:0] == '0);
                neg_d       = prod[WIDTH-1];
                carry_d     = 1'b0;
                ovf_d       = (prod[2*WIDTH-1:WIDTH] != {WIDTH{prod[WIDTH-1]}});
                done_d      = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mcand_q     <= '0;
            acc_q       <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            sign_q      <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b1;
            neg_q       <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            mcand_q     <= mcand_d;
            acc_q       <= acc_d;
            mplier_q    <= mplier_d;
            cnt_q       <= cnt_d;
            sign_q      <= sign_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            neg_q       <= neg_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            done_q      <= done_d;
        end
    end

    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;
    assign bus.result    = result_q;
    assign bus.result_hi = result_hi_q;
    assign bus.zero      = zero_q;
    assign bus.neg       = neg_q;
    assign bus.carry     = carry_q;
    assign bus.ovf       = ovf_q;
endmodule
